// File: rtl/weight_mem_pkg.sv
// weight_mem_pkg: constants and state type shared by the weight SRAM access blocks.
package weight_mem_pkg;

  localparam int WMEM_DEPTH = 16384;
  localparam int WMEM_AW    = 14;
  localparam int WMEM_DW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } wsr_state_t;

  // Word address after a, wrapping from WMEM_DEPTH-1 back to 0.
  function automatic logic [WMEM_AW-1:0] wmem_next_addr(input logic [WMEM_AW-1:0] a);
    return a + WMEM_AW'(1);
  endfunction

endpackage

// File: rtl/wsr_fifo.sv
// wsr_fifo: synchronous FIFO with occupancy count. Push and pop may occur in
// the same cycle at any occupancy, including full. DEPTH must be a power of two.
module wsr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage needs no reset; the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/weight_stream_reader.sv
// weight_stream_reader: reads a burst of sequential words from the weight SRAM
// and streams them on a valid/ready port. Reads are issued only when the output
// FIFO has room for the word plus any read still in flight, so backpressure
// never loses or repeats a word. The SRAM port is never written.
// Optional feature macro: WEIGHT_STREAM_READER_STALL_CNT_EN adds stall_cnt, a
// saturating count of cycles with out_valid && !out_ready for the last burst.
//
// state | meaning
// IDLE  | waiting for start; sram_addr holds the last read address
// FETCH | issuing one read per cycle while credit and issue count allow
// DRAIN | all reads issued; waiting for the final word to be accepted
module weight_stream_reader
  import weight_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = WMEM_DW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WMEM_AW-1:0]    base_addr,
  input  logic [WMEM_AW:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W/8-1:0]   sram_wea,
  output logic [15:0]           sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last
`ifdef WEIGHT_STREAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = WMEM_AW + 1;

  wsr_state_t          r_state;
  wsr_state_t          w_state_nxt;
  logic [WMEM_AW-1:0]  r_addr;
  logic [LW-1:0]       r_issue_cnt;
  logic [LW-1:0]       r_accept_cnt;
  logic                r_inflight;
  logic                r_done;

  logic                w_issue;
  logic                w_pop;
  logic                w_done_nxt;
  logic                w_start_acc;
  logic                w_credit;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_fifo_count;
  logic [DATA_W-1:0]   w_fifo_head;

  wsr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_wdata (sram_rdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign w_fifo_empty = (w_fifo_count == '0);
  assign w_pop        = out_valid && out_ready;
  // A read may go out only if its word and the one already in flight both fit.
  assign w_credit     = ({1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(FIFO_DEPTH);

  // Next-state and per-cycle control decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          if (len != '0) w_state_nxt = FETCH;
          else           w_done_nxt  = 1'b1;
        end
      end
      FETCH: begin
        if (r_issue_cnt != '0 && w_credit) begin
          w_issue = 1'b1;
          if (r_issue_cnt == LW'(1)) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pop && r_accept_cnt == LW'(1)) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Address, issue/accept counters, in-flight flag and done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_issue_cnt  <= '0;
      r_accept_cnt <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_done_nxt;
      if (w_start_acc && len != '0) begin
        r_addr       <= base_addr;
        r_issue_cnt  <= len;
        r_accept_cnt <= len;
      end else begin
        if (w_issue) begin
          r_issue_cnt <= r_issue_cnt - LW'(1);
          // Keep the final read address on the bus once the burst is issued.
          if (r_issue_cnt != LW'(1)) r_addr <= wmem_next_addr(r_addr);
        end
        if (w_pop) r_accept_cnt <= r_accept_cnt - LW'(1);
      end
    end
  end

`ifdef WEIGHT_STREAM_READER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating backpressure counter, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign sram_wea   = '0;
  assign sram_wdata = '0;
  assign sram_addr  = {{(16-WMEM_AW){1'b0}}, r_addr};
  assign out_valid  = !w_fifo_empty;
  assign out_data   = w_fifo_empty ? '0 : w_fifo_head;
  // The head is the final word when it is the only one left to be accepted.
  assign out_last   = out_valid && (r_accept_cnt == LW'(1));

endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader: scoreboard bench for weight_stream_reader.
module tb_weight_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [13:0] base_addr = '0;
  logic [14:0] len = '0;
  logic        busy;
  logic        done;
  logic [3:0]  sram_wea;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
`ifdef WEIGHT_STREAM_READER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  weight_stream_reader #(.FIFO_DEPTH(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .sram_wea   (sram_wea),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef WEIGHT_STREAM_READER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: every word holds its own address, one-cycle read latency.
  always @(posedge clk) sram_rdata <= {16'h0, sram_addr};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          hs_cnt, done_cnt, first_valid_cyc, done_cyc, last_hs_cyc, max_occ;
  bit          seen_done;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  int          c0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    hs_cnt = 0; done_cnt = 0; seen_done = 0;
    first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1; max_occ = 0;
  endtask

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", {31'b0, out_valid}, 32'd1);
        check("stall_data_held", out_data, prev_data);
        check("stall_last_held", {31'b0, out_last}, {31'b0, prev_last});
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_last", {31'b0, out_last}, {31'b0, e.l});
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_cnt++;
        seen_done = 1;
        done_cyc  = cyc;
      end
      if (int'(dut.u_fifo.o_count) > max_occ) max_occ = int'(dut.u_fifo.o_count);
    end
  end

  task automatic push_exp(input logic [13:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t        e;
      logic [13:0] a;
      a   = b + 14'(i);
      e.d = {18'h0, a};
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  // Runs one burst; toggle selects the 1,0,0,1 ready pattern, restart_i
  // injects a second start at that loop iteration.
  task automatic run_burst(input logic [13:0] b, input int n, input bit toggle, input int restart_i);
    logic [3:0] pat = 4'b1001;
    push_exp(b, n);
    clear_mon();
    out_ready = 1'b1;
    base_addr = b; len = 15'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    check("addr_at_start", {16'h0, sram_addr}, {18'h0, b});
    check("busy_at_start", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 400 && !seen_done; i++) begin
      if (toggle) out_ready = pat[i % 4];
      @(posedge clk); #1;
      if (i == restart_i) begin
        start = 1'b1; base_addr = 14'h0300; len = 15'd2;
      end else begin
        start = 1'b0;
      end
      if (!toggle && i + 1 < n) check("addr_seq", {16'h0, sram_addr}, {18'h0, b + 14'(i + 1)});
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_seen", {31'b0, seen_done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    check("words_accepted", hs_cnt, n);
    check("queue_drained", exp_q.size(), 0);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("done_after_last_hs", done_cyc, last_hs_cyc + 1);
    check("fifo_occ_le_4", {31'b0, max_occ <= 4}, 32'd1);
    if (!toggle) begin
      check("first_word_latency", first_valid_cyc - c0, 2);
      check("done_cycle", done_cyc - c0, n + 2);
    end
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    clear_mon();
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_sram_addr", {16'h0, sram_addr}, 32'd0);
    check("rst_sram_wea", {28'h0, sram_wea}, 32'd0);
    check("rst_sram_wdata", sram_wdata, 32'd0);
`ifdef WEIGHT_STREAM_READER_STALL_CNT_EN
    check("rst_stall_cnt", {16'h0, stall_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst, full throughput
    run_burst(14'h0010, 4, 1'b0, -1);
    // Same burst under backpressure
    run_burst(14'h0010, 4, 1'b1, -1);
    // Address wrap at the top of the SRAM
    run_burst(14'h3FFE, 4, 1'b0, -1);

    // Zero-length start: no reads, done next cycle, address untouched
    clear_mon();
    base_addr = 14'h0100; len = 15'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    check("len0_addr_hold", {16'h0, sram_addr}, 32'h0000_0001);
    check("len0_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("len0_done_cnt", done_cnt, 1);
    check("len0_done_cycle", done_cyc - c0, 0);
    check("len0_no_valid", {31'b0, first_valid_cyc < 0}, 32'd1);
    check("len0_addr_after", {16'h0, sram_addr}, 32'h0000_0001);

    // Start while busy is ignored
    run_burst(14'h0020, 5, 1'b0, 1);

    // Reset in the middle of a burst
    push_exp(14'h0040, 8);
    clear_mon();
    base_addr = 14'h0040; len = 15'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50 && hs_cnt < 2; i++) @(negedge clk);
    check("reached_word2", {31'b0, hs_cnt >= 2}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_last", {31'b0, out_last}, 32'd0);
    check("midrst_out_data", out_data, 32'd0);
    check("midrst_sram_addr", {16'h0, sram_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    clear_mon();
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_valid", {31'b0, first_valid_cyc < 0}, 32'd1);
    run_burst(14'h0050, 2, 1'b0, -1);

`ifdef WEIGHT_STREAM_READER_STALL_CNT_EN
    // Stall counter: five stalled cycles, then cleared by the next start
    push_exp(14'h0060, 2);
    clear_mon();
    out_ready = 1'b0;
    base_addr = 14'h0060; len = 15'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("stall_first_valid", {31'b0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      @(posedge clk); #1;
    end
    check("stall_done_seen", {31'b0, seen_done}, 32'd1);
    check("stall_cnt_at_done", {16'h0, stall_cnt}, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    check("stall_cnt_hold", {16'h0, stall_cnt}, 32'd5);
    exp_q.delete();
    push_exp(14'h0070, 1);
    clear_mon();
    base_addr = 14'h0070; len = 15'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("stall_cnt_cleared", {16'h0, stall_cnt}, 32'd0);
    for (int i = 0; i < 20 && !seen_done; i++) begin
      @(posedge clk); #1;
    end
    check("stall_second_done", {31'b0, seen_done}, 32'd1);
    exp_q.delete();
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
